deserializer_sipo: RTL and testbench
====================================

# deserializer_SIPO

Serial-in/parallel-out deserializer: the receive-side counterpart of the transceiver's PISO serializer. It collects bits from `srl_in` on cycles qualified by `shift`, MSB first, and assembles `DATA_WIDTH`-bit words. Completed words go to a one-word output register and are drained downstream with a valid/ready handshake. A `sync` strobe re-aligns word boundaries, and a sticky `overrun` flag reports words lost to back-pressure.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: word width; must be ≥ 2.

Ports:
- `clk`  in  1  single clock for the whole block; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
  - Assertion (low) forces every register to its reset value immediately.
  - Release is synchronous to `clk`.
- `srl_in`  in  1  serial data bit; sampled only when `shift`=1.
- `shift`  in  1  bit strobe; 1 = sample `srl_in` this cycle.
- `sync`  in  1  word-boundary strobe; discards any partial word.
- `data_out`  out  DATA_WIDTH  assembled word; first-received bit is in the MSB.
- `valid`  out  1  `data_out` holds an undelivered word.
- `ready`  in  1  downstream accepts `data_out` this cycle.
- `overrun`  out  1  sticky; a completed word was dropped.
- `busy`  out  1  a partial word is in progress (bit counter ≠ 0).

## Operation
Internal state:
- `sr`: DATA_WIDTH-1 bits.
- `cnt`: $clog2(DATA_WIDTH) bits, counts 0..DATA_WIDTH-1.
- Output register plus a `valid` flag.

Per rising edge, with `shift`=1 and `sync`=0:
- `sr` ← {`sr`[DW-3:0], `srl_in`}.
- `cnt` ← `cnt`+1.
- If `cnt`==DW-1, the word is complete:
  - Completed word w = {`sr`, `srl_in`}.
  - `cnt` wraps to 0.

When a word completes:
- If `valid`=0, or `valid`&`ready`=1 in the same cycle: `data_out` ← w and `valid` ← 1.
- Otherwise: w is discarded, `data_out` is unchanged, and `overrun` ← 1.

Handshake:
- A transfer occurs on any cycle with `valid`&`ready`.
- If no word completes in that cycle, `valid` ← 0 on the next edge.
- While `valid`=1 and `ready`=0, `data_out` is held stable.
- `ready` is ignored while `valid`=0.

`sync`=1:
- Clears `cnt` and discards the partial word.
- If `shift`=1 in the same cycle, that bit becomes bit 1 (the MSB) of the new word, and `cnt` ← 1.
- `sync` never completes a word, even when `cnt`==DW-1.
- The output register, `valid` and `overrun` are unaffected.

Other rules:
- `overrun` is cleared only by reset.
- `busy` = (`cnt` ≠ 0), taken directly from the register.
- There is no combinational path from any input to any output.

Reset values: `data_out`=0, `valid`=0, `overrun`=0, `busy`=0, `sr`=0, `cnt`=0.

## Timing
- Latency: `valid` and the new `data_out` appear on the edge that samples the last bit. They are visible in the following cycle, i.e. one cycle after the last `shift`.
- Throughput: one word per DATA_WIDTH `shift` cycles. `shift` may be asserted every cycle or with arbitrary gaps.
- Cycles without `shift` and without `sync` leave `sr` and `cnt` untouched.
- Drain and complete in the same edge:
  - `valid` stays 1 and `data_out` takes w.
  - There is no bubble and no overrun.
- Reset mid-word: the partial word, the output word and `overrun` are all lost. The next DATA_WIDTH shifted bits after release form a fresh word.

## Test plan
- Gap-free word: reset, then `ready`=1 and 8 consecutive `shift` cycles of bits 1,0,1,0,0,1,0,1 -> `valid`=1 with `data_out`=0xA5 in the cycle after the 8th shift; `valid`=0 in the next cycle; `busy`=1 during bits 2..8.
- Gapped `shift`: 0x3C sent with `shift` asserted every 3rd cycle -> exactly one word, `data_out`=0x3C, and no extra bits sampled during idle cycles.
- Back-pressure: `ready`=0, send 0x11 then 0x22 -> `data_out` stays 0x11; `overrun`=1 after the 16th bit; raising `ready` drops `valid` after one transfer; `overrun` remains 1.
- Simultaneous drain/load: 0x55 is pending with `valid`=1; `ready` rises in exactly the cycle the 8th bit of 0x99 is sampled -> `valid` stays 1, `data_out`=0x99, `overrun`=0.
- Re-sync: 3 junk bits, `sync` together with `shift` of bit 1, then 7 more bits of 0xF0 -> `data_out`=0xF0; a separate case with `sync`=1 and `cnt`=7 -> no word emitted.
- Async reset mid-word: drive `rst` low between edges after 4 bits -> `valid`, `data_out`, `overrun` and `busy` go to 0 immediately; after release, 0xC3 is assembled correctly.

Source files
------------

// File: rtl/deserializer_sipo.sv
// Serial-in/parallel-out deserializer: assembles MSB-first words from a strobed
// bit stream into a one-word output register drained with a valid/ready handshake.
module deserializer_sipo #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  srl_in,
  input  logic                  shift,
  input  logic                  sync,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  input  logic                  ready,
  output logic                  overrun,
  output logic                  busy
);

  localparam int              CW   = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-2:0] sr;
  logic [DATA_WIDTH-2:0] sr_next;
  logic [DATA_WIDTH-2:0] shifted;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_next;
  logic [DATA_WIDTH-1:0] word;
  logic                  complete;

  // A 2-bit word keeps only one stored bit, so there is nothing to shift along.
  generate
    if (DATA_WIDTH == 2) begin : g_narrow
      assign shifted = srl_in;
    end else begin : g_wide
      assign shifted = {sr[DATA_WIDTH-3:0], srl_in};
    end
  endgenerate

  assign word = {sr, srl_in};
  assign busy = (cnt != '0);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    sr_next  = sr;
    cnt_next = cnt;
    complete = 1'b0;
    if (sync) begin
      // sync never completes a word; a coincident bit starts the new one.
      cnt_next = '0;
      if (shift) begin
        sr_next  = shifted;
        cnt_next = CW'(1);
      end
    end else if (shift) begin
      sr_next = shifted;
      if (cnt == LAST) begin
        cnt_next = '0;
        complete = 1'b1;
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr  <= '0;
      cnt <= '0;
    end else begin
      sr  <= sr_next;
      cnt <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (complete && (!valid || ready)) begin
        // A drain in the same edge frees the slot, so the new word loads with no bubble.
        data_out <= word;
        valid    <= 1'b1;
      end else if (complete) begin
        overrun <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_deserializer_sipo.sv
// Directed self-checking bench for deserializer_sipo with DATA_WIDTH = 8.
module tb_deserializer_sipo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       srl_in = 1'b0;
  logic       shift = 1'b0;
  logic       sync = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] data_out;
  logic       valid;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  deserializer_sipo #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .srl_in   (srl_in),
    .shift    (shift),
    .sync     (sync),
    .data_out (data_out),
    .valid    (valid),
    .ready    (ready),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    shift = 1'b0;
    sync = 1'b0;
    ready = 1'b0;
    step();
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic send_bit(input logic b);
    shift  = 1'b1;
    srl_in = b;
    step();
    shift  = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if ({data_out, valid, overrun, busy} !== 11'b0) begin
      errors++;
      $display("FAIL reset_state: got data=%h valid=%b ovr=%b busy=%b, want all 0",
               data_out, valid, overrun, busy);
    end
    do_reset();
  endtask

  task automatic test_gap_free();
    logic [7:0] w;
    w = 8'hA5;
    ready = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i]);
      if (i > 0) begin
        checks++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
          errors++;
          $display("FAIL gap_free_busy bit%0d: got busy=%b valid=%b, want busy=1 valid=0",
                   8 - i, busy, valid);
        end
      end
    end
    checks++;
    if (valid !== 1'b1 || data_out !== 8'hA5 || busy !== 1'b0) begin
      errors++;
      $display("FAIL gap_free_word: got valid=%b data=%h busy=%b, want 1 a5 0", valid, data_out, busy);
    end
    step();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL gap_free_drain: got valid=%b, want 0", valid);
    end
  endtask

  task automatic test_gapped();
    logic [7:0] w;
    int         words;
    w = 8'h3C;
    words = 0;
    ready = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i]);
      if (valid === 1'b1) words++;
      if (i > 0) begin
        srl_in = ~w[i];
        step();
        if (valid === 1'b1) words++;
        step();
        if (valid === 1'b1) words++;
      end
    end
    checks++;
    if (valid !== 1'b1 || data_out !== 8'h3C) begin
      errors++;
      $display("FAIL gapped_word: got valid=%b data=%h, want 1 3c", valid, data_out);
    end
    step();
    checks++;
    if (words !== 1 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL gapped_count: got words=%0d valid=%b busy=%b, want 1 0 0", words, valid, busy);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready = 1'b0;
    send_word(8'h11);
    checks++;
    if (valid !== 1'b1 || data_out !== 8'h11 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL bp_first: got valid=%b data=%h ovr=%b, want 1 11 0", valid, data_out, overrun);
    end
    send_word(8'h22);
    checks++;
    if (valid !== 1'b1 || data_out !== 8'h11 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_overrun: got valid=%b data=%h ovr=%b, want 1 11 1", valid, data_out, overrun);
    end
    ready = 1'b1;
    step();
    checks++;
    if (valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain: got valid=%b ovr=%b, want 0 1", valid, overrun);
    end
    step();
    checks++;
    if (overrun !== 1'b1 || data_out !== 8'h11) begin
      errors++;
      $display("FAIL bp_sticky: got ovr=%b data=%h, want 1 11", overrun, data_out);
    end
  endtask

  task automatic test_drain_load();
    logic [7:0] w;
    do_reset();
    ready = 1'b0;
    send_word(8'h55);
    w = 8'h99;
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    checks++;
    if (valid !== 1'b1 || data_out !== 8'h55) begin
      errors++;
      $display("FAIL dl_hold: got valid=%b data=%h, want 1 55", valid, data_out);
    end
    ready = 1'b1;
    send_bit(w[0]);
    checks++;
    if (valid !== 1'b1 || data_out !== 8'h99 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL dl_same_edge: got valid=%b data=%h ovr=%b, want 1 99 0", valid, data_out, overrun);
    end
    step();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL dl_drain: got valid=%b, want 0", valid);
    end
  endtask

  task automatic test_resync();
    logic [7:0] w;
    do_reset();
    ready = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    w = 8'hF0;
    sync = 1'b1;
    send_bit(w[7]);
    sync = 1'b0;
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL resync_start: got busy=%b valid=%b, want 1 0", busy, valid);
    end
    for (int i = 6; i >= 0; i--) send_bit(w[i]);
    checks++;
    if (valid !== 1'b1 || data_out !== 8'hF0) begin
      errors++;
      $display("FAIL resync_word: got valid=%b data=%h, want 1 f0", valid, data_out);
    end
    step();
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    sync = 1'b1;
    send_bit(1'b0);
    sync = 1'b0;
    checks++;
    if (valid !== 1'b0 || data_out !== 8'hF0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL resync_no_word: got valid=%b data=%h busy=%b, want 0 f0 1", valid, data_out, busy);
    end
    sync = 1'b1;
    step();
    sync = 1'b0;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL resync_clear: got busy=%b valid=%b, want 0 0", busy, valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ready = 1'b0;
    send_word(8'h5A);
    send_word(8'hFF);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    checks++;
    if (valid !== 1'b1 || overrun !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got valid=%b ovr=%b busy=%b, want 1 1 1", valid, overrun, busy);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({data_out, valid, overrun, busy} !== 11'b0) begin
      errors++;
      $display("FAIL areset_immediate: got data=%h valid=%b ovr=%b busy=%b, want all 0",
               data_out, valid, overrun, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    ready = 1'b1;
    send_word(8'hC3);
    checks++;
    if (valid !== 1'b1 || data_out !== 8'hC3 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL areset_after: got valid=%b data=%h ovr=%b, want 1 c3 0", valid, data_out, overrun);
    end
  endtask

  initial begin
    test_reset();
    test_gap_free();
    test_gapped();
    test_backpressure();
    test_drain_load();
    test_resync();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
